rr_burst_mux_arbiter: RTL and testbench



---
 rtl/rr_burst_mux_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_burst_mux_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_mux_arbiter.sv
// Round-robin, burst-locking arbiter feeding a shared N:1 mux into a one-entry
// registered output buffer. A winner owns the mux until its last beat is accepted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no owner; rotating-priority scan from ptr picks each beat
// S_LOCKED | owner_q holds the mux until its last beat is accepted

module rr_burst_mux_arbiter #(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*W-1:0]     req_data,
  input  logic [N-1:0]       req_last,
  output logic [N-1:0]       req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic               out_last,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   owner_q;
  logic               out_valid_q;
  logic [W-1:0]       out_data_q;
  logic               out_last_q;
  logic [SEL_W-1:0]   out_sel_q;
  logic               busy_q;

  logic               can_accept;
  logic               win_found;
  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W-1:0]   scan_idx;
  logic               xfer;
  logic [SEL_W-1:0]   out_sel_d;
  logic [W-1:0]       out_data_d;
  logic               out_last_d;

  // First valid requester at or after ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = ptr_q + SEL_W'(k);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Ready never depends on req_last or on ready itself, so no comb loops upstream.
  always_comb begin
    can_accept = !out_valid_q || out_ready;
    req_ready  = '0;
    out_sel_d  = win_idx;
    if (state_q == S_LOCKED) begin
      out_sel_d          = owner_q;
      req_ready[owner_q] = can_accept && req_valid[owner_q];
    end else if (win_found && can_accept) begin
      req_ready[win_idx] = 1'b1;
    end
    xfer       = |req_ready;
    out_data_d = req_data[out_sel_d*W +: W];
    out_last_d = req_last[out_sel_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_last_q  <= out_last_d;
        out_sel_q   <= out_sel_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            if (out_last_d) begin
              ptr_q <= out_sel_d + SEL_W'(1);
            end else begin
              state_q <= S_LOCKED;
              owner_q <= out_sel_d;
              busy_q  <= 1'b1;
            end
          end
        end
        S_LOCKED: begin
          // A stalled owner keeps the lock indefinitely; only its last beat releases it.
          if (xfer && out_last_d) begin
            state_q <= S_IDLE;
            ptr_q   <= owner_q + SEL_W'(1);
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rr_burst_mux_arbiter.sv
// Directed, table-driven bench for rr_burst_mux_arbiter (N=4, W=8): one row per
// cycle, inputs driven after the rising edge and outputs compared on the falling edge.

module tb_rr_burst_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rr_burst_mux_arbiter #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  er;
    logic        eov;
    logic [7:0]  eod;
    logic        eol;
    logic [1:0]  esel;
    logic        ebusy;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl [NV];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic ordy);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    out_ready = ordy;
    @(negedge clk);
  endtask

  // Producer contract: a held (valid, not ready) beat keeps its data and last.
  logic [3:0]  pv_q = '0;
  logic [3:0]  pr_q = '0;
  logic [31:0] pd_q = '0;
  logic [3:0]  pl_q = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pv_q[i] && !pr_q[i] && req_valid[i] && !rst &&
          (req_data[i*8 +: 8] !== pd_q[i*8 +: 8] || req_last[i] !== pl_q[i])) begin
        errors++;
        $display("FAIL producer_stable req %0d: data %0h last %0b, held %0h %0b",
                 i, req_data[i*8 +: 8], req_last[i], pd_q[i*8 +: 8], pl_q[i]);
      end
    end
    pv_q <= req_valid;
    pr_q <= req_ready;
    pd_q <= req_data;
    pl_q <= req_last;
  end

  initial begin
    //           rst  v        l        data          ordy er       ov    od     ol    sel   busy
    // all four valid, all last: 0,1,2,3,0 one beat per cycle
    tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 32'h33221100, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 32'h33221100, 1'b1, 4'b0010, 1'b1, 8'h00, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 32'h33221100, 1'b1, 4'b0100, 1'b1, 8'h11, 1'b1, 2'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 32'h33221100, 1'b1, 4'b1000, 1'b1, 8'h22, 1'b1, 2'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 32'h33221100, 1'b1, 4'b0001, 1'b1, 8'h33, 1'b1, 2'd3, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h00, 1'b1, 2'd0, 1'b0};
    // requester 2 burst A0..A2 while requester 0 waits (ptr=1)
    tbl[6]  = '{1'b0, 4'b0101, 4'b0001, 32'h00A00005, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0101, 4'b0001, 32'h00A10005, 1'b1, 4'b0100, 1'b1, 8'hA0, 1'b0, 2'd2, 1'b1};
    tbl[8]  = '{1'b0, 4'b0101, 4'b0101, 32'h00A20005, 1'b1, 4'b0100, 1'b1, 8'hA1, 1'b0, 2'd2, 1'b1};
    tbl[9]  = '{1'b0, 4'b0001, 4'b0001, 32'h00000005, 1'b1, 4'b0001, 1'b1, 8'hA2, 1'b1, 2'd2, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h05, 1'b1, 2'd0, 1'b0};
    // backpressure 3 cycles, then drain and refill in the same cycle
    tbl[11] = '{1'b0, 4'b0010, 4'b0010, 32'h00001100, 1'b0, 4'b0010, 1'b0, 8'h05, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 4'b0010, 4'b0010, 32'h00001200, 1'b0, 4'b0000, 1'b1, 8'h11, 1'b1, 2'd1, 1'b0};
    tbl[13] = '{1'b0, 4'b0010, 4'b0010, 32'h00001200, 1'b0, 4'b0000, 1'b1, 8'h11, 1'b1, 2'd1, 1'b0};
    tbl[14] = '{1'b0, 4'b0010, 4'b0010, 32'h00001200, 1'b0, 4'b0000, 1'b1, 8'h11, 1'b1, 2'd1, 1'b0};
    tbl[15] = '{1'b0, 4'b0010, 4'b0010, 32'h00001200, 1'b1, 4'b0010, 1'b1, 8'h11, 1'b1, 2'd1, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h12, 1'b1, 2'd1, 1'b0};
    // serve 2 -> ptr=3; 3 beats 0; then ptr wraps to 0
    tbl[17] = '{1'b0, 4'b0100, 4'b0100, 32'h00200000, 1'b1, 4'b0100, 1'b0, 8'h12, 1'b1, 2'd1, 1'b0};
    tbl[18] = '{1'b0, 4'b1001, 4'b1001, 32'h30000009, 1'b1, 4'b1000, 1'b1, 8'h20, 1'b1, 2'd2, 1'b0};
    tbl[19] = '{1'b0, 4'b0001, 4'b0001, 32'h00000009, 1'b1, 4'b0001, 1'b1, 8'h30, 1'b1, 2'd3, 1'b0};
    tbl[20] = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h09, 1'b1, 2'd0, 1'b0};
    // owner 1 mid-burst, reset for one cycle, then 0 wins from ptr=0
    tbl[21] = '{1'b0, 4'b0010, 4'b0000, 32'h00004000, 1'b1, 4'b0010, 1'b0, 8'h09, 1'b1, 2'd0, 1'b0};
    tbl[22] = '{1'b0, 4'b0011, 4'b0001, 32'h00004150, 1'b1, 4'b0010, 1'b1, 8'h40, 1'b0, 2'd1, 1'b1};
    tbl[23] = '{1'b1, 4'b0011, 4'b0001, 32'h00004150, 1'b1, 4'b0010, 1'b1, 8'h41, 1'b0, 2'd1, 1'b1};
    tbl[24] = '{1'b0, 4'b0011, 4'b0011, 32'h00004250, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    tbl[25] = '{1'b0, 4'b0010, 4'b0010, 32'h00004200, 1'b1, 4'b0010, 1'b1, 8'h50, 1'b1, 2'd0, 1'b0};
    tbl[26] = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h42, 1'b1, 2'd1, 1'b0};
    // owner 3 stalls 4 cycles mid-burst while 0 is valid
    tbl[27] = '{1'b0, 4'b1001, 4'b0001, 32'h6000000A, 1'b1, 4'b1000, 1'b0, 8'h42, 1'b1, 2'd1, 1'b0};
    tbl[28] = '{1'b0, 4'b0001, 4'b0001, 32'h6100000A, 1'b1, 4'b0000, 1'b1, 8'h60, 1'b0, 2'd3, 1'b1};
    tbl[29] = '{1'b0, 4'b0001, 4'b0001, 32'h6100000A, 1'b1, 4'b0000, 1'b0, 8'h60, 1'b0, 2'd3, 1'b1};
    tbl[30] = '{1'b0, 4'b0001, 4'b0001, 32'h6100000A, 1'b1, 4'b0000, 1'b0, 8'h60, 1'b0, 2'd3, 1'b1};
    tbl[31] = '{1'b0, 4'b0001, 4'b0001, 32'h6100000A, 1'b1, 4'b0000, 1'b0, 8'h60, 1'b0, 2'd3, 1'b1};
    tbl[32] = '{1'b0, 4'b1001, 4'b1001, 32'h6100000A, 1'b1, 4'b1000, 1'b0, 8'h60, 1'b0, 2'd3, 1'b1};
    tbl[33] = '{1'b0, 4'b0001, 4'b0001, 32'h0000000A, 1'b1, 4'b0001, 1'b1, 8'h61, 1'b1, 2'd3, 1'b0};
    tbl[34] = '{1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h0A, 1'b1, 2'd0, 1'b0};

    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", -1, 32'(out_valid), 32'd0);
    chk("reset_out_data",  -1, 32'(out_data),  32'd0);
    chk("reset_out_last",  -1, 32'(out_last),  32'd0);
    chk("reset_out_sel",   -1, 32'(out_sel),   32'd0);
    chk("reset_busy",      -1, 32'(busy),      32'd0);
    chk("reset_ready",     -1, 32'(req_ready), 32'd0);

    for (int r = 0; r < NV; r++) begin
      drive(tbl[r].rst, tbl[r].v, tbl[r].l, tbl[r].d, tbl[r].ordy);
      chk("req_ready", r, 32'(req_ready), 32'(tbl[r].er));
      chk("out_valid", r, 32'(out_valid), 32'(tbl[r].eov));
      chk("out_data",  r, 32'(out_data),  32'(tbl[r].eod));
      chk("out_last",  r, 32'(out_last),  32'(tbl[r].eol));
      chk("out_sel",   r, 32'(out_sel),   32'(tbl[r].esel));
      chk("busy",      r, 32'(busy),      32'(tbl[r].ebusy));
    end

    // Reset while locked with a stalled full buffer: lock, buffer and ptr all clear.
    drive(1'b0, 4'b0100, 4'b0000, 32'h00770000, 1'b0);
    chk("seq_lock_ready", 100, 32'(req_ready), 32'b0100);
    drive(1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b0);
    chk("seq_locked_busy", 101, 32'(busy), 32'd1);
    chk("seq_locked_data", 101, 32'(out_data), 32'h77);
    chk("seq_locked_ov",   101, 32'(out_valid), 32'd1);
    drive(1'b0, 4'b0011, 4'b0011, 32'h00004455, 1'b1);
    chk("seq_rst_ov",    102, 32'(out_valid), 32'd0);
    chk("seq_rst_busy",  102, 32'(busy), 32'd0);
    chk("seq_rst_ready", 102, 32'(req_ready), 32'b0001);
    drive(1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1);
    chk("seq_rst_out", 103, 32'(out_data), 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
